dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 28 ++
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundled request/response signals for the two data-memory ports plus the memory-side bus.
// The arbiter uses the slave modport; requesters and the memory model use master.
interface dmem_arbiter_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [31:0] a0, a1;
  logic [31:0] wd0, wd1;
  logic        gnt0, gnt1;
  logic        rvalid0, rvalid1;
  logic [31:0] rd0, rd1;
  logic        err0, err1;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport master (
    output req0, req1, we0, we1, a0, a1, wd0, wd1, mem_rd,
    input  gnt0, gnt1, rvalid0, rvalid1, rd0, rd1, err0, err1,
    input  mem_we, mem_a, mem_wd
  );

  modport slave (
    input  req0, req1, we0, we1, a0, a1, wd0, wd1, mem_rd,
    output gnt0, gnt1, rvalid0, rvalid1, rd0, rd1, err0, err1,
    output mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) data-memory arbiter with hold-count fairness and one-cycle completions.
// Define DMEM_ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
//
// state | meaning
// IDLE  | no grant last cycle
// OWN0  | port 0 granted last cycle
// OWN1  | port 1 granted last cycle
module dmem_arbiter #(
  parameter int DEPTH_WORDS = 64,
  parameter int MAX_HOLD    = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [3:0]  HOLD_LIM  = 4'(MAX_HOLD);

  state_t      state, state_nxt;
  logic [3:0]  hold, hold_nxt, hold_inc;
  logic        gnt0, gnt1;
  logic        both_req;
  logic        hold_hit;
  logic        pref1;
  logic        illegal0, illegal1;

  logic        rvalid0_q, rvalid1_q;
  logic [31:0] rd0_q, rd1_q;
  logic        err0_q, err1_q;

  assign illegal0 = (bus.a0[1:0] != 2'b00) || (bus.a0[31:2] >= DEPTH_LIM);
  assign illegal1 = (bus.a1[1:0] != 2'b00) || (bus.a1[31:2] >= DEPTH_LIM);

  assign both_req = bus.req0 && bus.req1;
  assign hold_hit = (hold >= HOLD_LIM);
  assign hold_inc = (hold == 4'hF) ? hold : hold + 4'd1;

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr, rr_ptr_nxt;

  assign pref1 = rr_ptr;

  // Pointer flips to the loser only after contended grants.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (both_req && gnt0) rr_ptr_nxt = 1'b1;
    if (both_req && gnt1) rr_ptr_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr <= 1'b0;
    else       rr_ptr <= rr_ptr_nxt;
  end
`else
  assign pref1 = 1'b0;
`endif

  // Preferred port wins contention unless it already owns the bus and has used up its hold budget.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = IDLE;
    hold_nxt  = 4'd0;
    if (!reset) begin
      if (both_req) begin
        if (!pref1) begin
          if (state == OWN0 && hold_hit) gnt1 = 1'b1;
          else                           gnt0 = 1'b1;
        end else begin
          if (state == OWN1 && hold_hit) gnt0 = 1'b1;
          else                           gnt1 = 1'b1;
        end
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end

      if (gnt0) begin
        state_nxt = OWN0;
        hold_nxt  = (state == OWN0) ? hold_inc : 4'd1;
      end else if (gnt1) begin
        state_nxt = OWN1;
        hold_nxt  = (state == OWN1) ? hold_inc : 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hold  <= 4'd0;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
    end
  end

  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;

  always_comb begin
    bus.mem_a  = 32'd0;
    bus.mem_wd = 32'd0;
    bus.mem_we = 1'b0;
    if (gnt0) begin
      bus.mem_a  = bus.a0;
      bus.mem_wd = bus.wd0;
      bus.mem_we = bus.we0 && !illegal0;
    end else if (gnt1) begin
      bus.mem_a  = bus.a1;
      bus.mem_wd = bus.wd1;
      bus.mem_we = bus.we1 && !illegal1;
    end
  end

  // Completion registers keep their last value between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rd0_q     <= 32'd0;
      rd1_q     <= 32'd0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      if (gnt0) begin
        err0_q <= illegal0;
        rd0_q  <= (!bus.we0 && !illegal0) ? bus.mem_rd : 32'd0;
      end
      if (gnt1) begin
        err1_q <= illegal1;
        rd1_q  <= (!bus.we1 && !illegal1) ? bus.mem_rd : 32'd0;
      end
    end
  end

  // Reset masks the outputs immediately so a grant's pulse is dropped if reset follows it.
  assign bus.rvalid0 = rvalid0_q && !reset;
  assign bus.rvalid1 = rvalid1_q && !reset;
  assign bus.rd0     = reset ? 32'd0 : rd0_q;
  assign bus.rd1     = reset ? 32'd0 : rd1_q;
  assign bus.err0    = err0_q && !reset;
  assign bus.err1    = err1_q && !reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected grants/completions, a negedge monitor checks them.
// Expected arbitration pattern follows DMEM_ARB_RR_EN when it is defined for the build.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(.DEPTH_WORDS(64), .MAX_HOLD(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
  } gnt_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } res_t;

  gnt_t gq[$];
  res_t rq0[$];
  res_t rq1[$];

  function automatic logic [31:0] memv(int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  function automatic logic legal(logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:2] < 30'd64);
  endfunction

  // Memory model attached to the arbiter's memory bus
  logic [31:0] mem [0:63];
  assign bus.mem_rd = mem[bus.mem_a[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= memv(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_a[7:2]] <= bus.mem_wd;
    end
  end

  // Monitor
  always @(negedge clk) begin : mon
    gnt_t g;
    res_t r;
    int   gp;
    logic exp_we;
    if (bus.gnt0 && bus.gnt1) begin
      checks++; errors++;
      $display("FAIL dual_grant gnt0=%0b gnt1=%0b required at most one", bus.gnt0, bus.gnt1);
    end
    if (bus.gnt0 || bus.gnt1) begin
      checks++;
      gp = bus.gnt1 ? 1 : 0;
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant port=%0d required no grant", gp);
      end else begin
        g = gq.pop_front();
        exp_we = g.we && legal(g.a);
        if (gp != g.port || bus.mem_we !== exp_we || bus.mem_a !== g.a || bus.mem_wd !== g.wd) begin
          errors++;
          $display("FAIL grant port=%0d we=%0b a=%h wd=%h required port=%0d we=%0b a=%h wd=%h",
                   gp, bus.mem_we, bus.mem_a, bus.mem_wd, g.port, exp_we, g.a, g.wd);
        end
      end
    end else begin
      checks++;
      if (bus.mem_we !== 1'b0 || bus.mem_a !== 32'd0 || bus.mem_wd !== 32'd0) begin
        errors++;
        $display("FAIL idle_bus we=%0b a=%h wd=%h required all zero", bus.mem_we, bus.mem_a, bus.mem_wd);
      end
    end
    if (bus.rvalid0) begin
      checks++;
      if (rq0.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid0 rd=%h err=%0b required no completion", bus.rd0, bus.err0);
      end else begin
        r = rq0.pop_front();
        if (bus.rd0 !== r.rd || bus.err0 !== r.err) begin
          errors++;
          $display("FAIL completion0 rd=%h err=%0b required rd=%h err=%0b", bus.rd0, bus.err0, r.rd, r.err);
        end
      end
    end
    if (bus.rvalid1) begin
      checks++;
      if (rq1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid1 rd=%h err=%0b required no completion", bus.rd1, bus.err1);
      end else begin
        r = rq1.pop_front();
        if (bus.rd1 !== r.rd || bus.err1 !== r.err) begin
          errors++;
          $display("FAIL completion1 rd=%h err=%0b required rd=%h err=%0b", bus.rd1, bus.err1, r.rd, r.err);
        end
      end
    end
  end

  task automatic expect_grant(int port, logic we, logic [31:0] a, logic [31:0] wd);
    gnt_t g;
    g.port = port; g.we = we; g.a = a; g.wd = wd;
    gq.push_back(g);
  endtask

  task automatic expect_access(int port, logic we, logic [31:0] a, logic [31:0] wd,
                               logic [31:0] rd_exp, logic err_exp);
    res_t r;
    expect_grant(port, we, a, wd);
    r.rd = rd_exp; r.err = err_exp;
    if (port == 0) rq0.push_back(r);
    else           rq1.push_back(r);
  endtask

  task automatic drive(int port, logic req, logic we, logic [31:0] a, logic [31:0] wd);
    if (port == 0) begin
      bus.req0 = req; bus.we0 = we; bus.a0 = a; bus.wd0 = wd;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.a1 = a; bus.wd1 = wd;
    end
  endtask

  task automatic single(int port, logic we, logic [31:0] a, logic [31:0] wd,
                        logic [31:0] rd_exp, logic err_exp);
    int   n;
    logic seen;
    expect_access(port, we, a, wd, rd_exp, err_exp);
    @(posedge clk); #1;
    drive(port, 1'b1, we, a, wd);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = (port == 0) ? bus.gnt0 : bus.gnt1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL grant_timeout port=%0d waited=%0d cycles required a grant", port, n);
    end
    @(posedge clk); #1;
    drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic check_zero_outputs(string tag);
    checks++;
    if (bus.gnt0 || bus.gnt1 || bus.mem_we || bus.rvalid0 || bus.rvalid1 || bus.err0 || bus.err1 ||
        bus.rd0 !== 32'd0 || bus.rd1 !== 32'd0 || bus.mem_a !== 32'd0 || bus.mem_wd !== 32'd0) begin
      errors++;
      $display("FAIL %s gnt=%0b%0b we=%0b rv=%0b%0b err=%0b%0b rd0=%h rd1=%h a=%h wd=%h required all zero",
               tag, bus.gnt0, bus.gnt1, bus.mem_we, bus.rvalid0, bus.rvalid1, bus.err0, bus.err1,
               bus.rd0, bus.rd1, bus.mem_a, bus.mem_wd);
    end
  endtask

`ifdef DMEM_ARB_RR_EN
  int pattern [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
  int pattern [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
`endif

  initial begin
    reset    = 1'b1;
    mem_init = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    // A write request during reset must be neither granted nor written
    drive(0, 1'b1, 1'b1, 32'h40, 32'h5555_5555);
    repeat (3) begin
      @(negedge clk);
      check_zero_outputs("reset_state");
    end
    @(posedge clk); #1;
    reset    = 1'b0;
    mem_init = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Write then read back on port 0
    single(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0);
    single(0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);
    // Request made during reset left mem[16] untouched
    single(0, 1'b0, 32'h40, 32'd0, memv(16), 1'b0);

    // Last legal word on port 1
    single(1, 1'b1, 32'hFC, 32'hCAFE_F00D, 32'd0, 1'b0);
    single(1, 1'b0, 32'hFC, 32'd0, 32'hCAFE_F00D, 1'b0);

    // Illegal accesses: misaligned and one past the end
    single(1, 1'b1, 32'h102, 32'h1111_1111, 32'd0, 1'b1);
    single(1, 1'b1, 32'h100, 32'h2222_2222, 32'd0, 1'b1);
    single(1, 1'b0, 32'h100, 32'd0, 32'd0, 1'b1);
    single(0, 1'b0, 32'h0, 32'd0, memv(0), 1'b0);

    // Alternating ports in consecutive cycles
    expect_access(0, 1'b0, 32'h20, 32'd0, memv(8), 1'b0);
    expect_access(1, 1'b0, 32'h24, 32'd0, memv(9), 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h20, 32'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b1, 1'b0, 32'h24, 32'd0);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

    // Back-to-back reads on one port
    expect_access(0, 1'b0, 32'h20, 32'd0, memv(8), 1'b0);
    expect_access(0, 1'b0, 32'h24, 32'd0, memv(9), 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h20, 32'd0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h24, 32'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);

    // Reset the cycle after a grant drops the completion; held request wins right after reset
    #1;
    expect_grant(0, 1'b0, 32'h20, 32'd0);
    drive(0, 1'b1, 1'b0, 32'h20, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_zero_outputs("reset_after_grant");
    @(posedge clk); #1;
    reset = 1'b0;
    expect_access(0, 1'b0, 32'h20, 32'd0, memv(8), 1'b0);
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_grant gnt0=%0b required 1", bus.gnt0);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);

    // Contention: both ports held for 12 cycles starting from a fresh reset
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (pattern[i] == 0) expect_access(0, 1'b0, 32'h0, 32'd0, memv(0), 1'b0);
      else                 expect_access(1, 1'b0, 32'h4, 32'd0, memv(1), 1'b0);
    end
    drive(0, 1'b1, 1'b0, 32'h0, 32'd0);
    drive(1, 1'b1, 1'b0, 32'h4, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

    repeat (4) @(negedge clk);
    checks++;
    if (gq.size() != 0) begin
      errors++;
      $display("FAIL grants_outstanding left=%0d required 0", gq.size());
    end
    checks++;
    if (rq0.size() != 0) begin
      errors++;
      $display("FAIL completions0_outstanding left=%0d required 0", rq0.size());
    end
    checks++;
    if (rq1.size() != 0) begin
      errors++;
      $display("FAIL completions1_outstanding left=%0d required 0", rq1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
